trig_acq_ctrl: RTL and testbench
================================

Name: trig_acq_ctrl

Overview:
- Trigger/acquisition sequencer placed directly downstream of the pulse-width trigger qualifier.
- Consumes the qualified status level and converts its rising edge into a single-cycle trigger event.
- Sequences pre-trigger fill, post-trigger fill and holdoff, and drives the sample-memory write enable and the acquisition-done strobe to the capture/readout logic.
- Supports normal, auto (forced trigger on timeout) and single-shot modes.

Parameters:
- CNT_W, 32, width of all length/timeout inputs and internal interval counters.
- TCNT_W, 16, width of trig_count.

Ports:
- cnt_clk  in  1  sample clock, same domain as the pulse-width qualifier.
- cnt_clr  in  1  reset, asynchronous, active-low.
- pul_trig_status  in  1  qualified trigger level from the pulse-width stage, synchronous to cnt_clk.
- arm  in  1  single-cycle pulse; starts a sequence from IDLE.
- abort  in  1  level; forces IDLE.
- mode  in  2  00 normal, 01 auto, 10 single, 11 treated as normal.
- pretrig_len  in  CNT_W  pre-trigger samples.
- posttrig_len  in  CNT_W  post-trigger samples; 0 treated as 1.
- holdoff_len  in  CNT_W  cycles ignored after done.
- auto_timeout  in  CNT_W  WAIT_TRIG cycles before a forced trigger in auto mode.
- trig_out  out  1  one-cycle trigger event.
- trig_forced  out  1  high together with trig_out when the trigger was forced by timeout.
- acq_wr_en  out  1  sample-memory write enable.
- acq_done  out  1  one-cycle pulse at end of post-fill.
- busy  out  1  high in every state except IDLE.
- trig_count  out  TCNT_W  wrapping count of trig_out pulses.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, status_d 0.
- Edge detect:
  - status_d <= pul_trig_status every cycle.
  - edge = pul_trig_status & ~status_d.
  - trig_out is registered, so it asserts one cycle after the first high sample.
- States: IDLE, PRE_FILL, WAIT_TRIG, POST_FILL, HOLDOFF. Length inputs are sampled on entry to the state that uses them.
- IDLE:
  - acq_wr_en 0.
  - arm=1 -> PRE_FILL with counter cleared. If pretrig_len=0, go directly to WAIT_TRIG instead.
- PRE_FILL:
  - acq_wr_en 1; counter increments each cycle.
  - When counter reaches pretrig_len-1 -> WAIT_TRIG. acq_wr_en is high for exactly pretrig_len cycles.
  - Edges are ignored in this state.
- WAIT_TRIG:
  - acq_wr_en 1.
  - On edge: trig_out=1, trig_count++ (wraps at 2^TCNT_W), go to POST_FILL.
  - Auto mode with no edge: timeout counter increments each cycle. When it reaches auto_timeout-1, trig_out=1 and trig_forced=1, then POST_FILL.
  - auto_timeout=0 forces a trigger on the first WAIT_TRIG cycle.
  - If the status level is already high on entry, there is no trigger until it falls and rises again.
  - If edge and timeout occur in the same cycle, the edge wins and trig_forced=0.
- POST_FILL:
  - acq_wr_en 1. The trig_out cycle counts as post sample 1.
  - acq_wr_en stays high for max(posttrig_len,1) cycles including that cycle.
  - The cycle after the last post sample: acq_wr_en 0, acq_done=1, go to HOLDOFF.
- HOLDOFF:
  - acq_wr_en 0; edges ignored; count holdoff_len cycles (0 means zero cycles).
  - Then: single mode -> IDLE; normal/auto -> PRE_FILL (auto re-arm, same rules as arm from IDLE).
- Priority:
  - abort=1 in any state -> IDLE next cycle; acq_wr_en, trig_out and acq_done all 0.
  - abort has priority over trig_out.
  - arm outside IDLE is ignored.
- mode changes are honoured at the next state transition only.
- cnt_clr mid-operation: immediate return to the reset values listed above.

Decomposition:
- Shared package trig_acq_pkg:
  - state encoding enum (IDLE=0, PRE_FILL=1, WAIT_TRIG=2, POST_FILL=3, HOLDOFF=4);
  - mode constants MODE_NORMAL, MODE_AUTO, MODE_SINGLE.
- One sub-module, trig_interval_cnt (CNT_W-bit clear/enable counter with terminal-count compare), instantiated for the shared fill/holdoff counter and for the auto-timeout counter.

Test Plan:
- Normal mode, pretrig=4, posttrig=6, holdoff=3; arm, status rises 10 cycles into WAIT_TRIG -> acq_wr_en high 4 cycles pre-trigger plus the wait cycles; trig_out 1 cycle after the edge; acq_wr_en high 6 cycles from trig_out; acq_done 1 cycle; re-enters PRE_FILL 3 cycles later; trig_count=1.
- Status pulses during PRE_FILL and HOLDOFF, and status already high on WAIT_TRIG entry -> no trig_out until a fresh rising edge inside WAIT_TRIG.
- Auto mode, auto_timeout=20, status held 0 -> trig_out and trig_forced together exactly 20 cycles after WAIT_TRIG entry; an edge on cycle 20 instead -> trig_forced=0.
- Single mode, two sequences' worth of status edges -> exactly one trig_out and one acq_done, then busy=0 and IDLE; a new arm restarts the sequence.
- abort asserted in POST_FILL cycle 2 -> IDLE next cycle, acq_wr_en=0, no acq_done; cnt_clr pulsed in WAIT_TRIG -> all outputs 0, trig_count=0.
- Boundaries: pretrig=0, posttrig=0, holdoff=0 -> WAIT_TRIG on the cycle after arm, a single post sample, immediate re-arm; trig_count wraps from 0xFFFF to 0x0000.

Source files
------------

// File: rtl/trig_acq_pkg.sv
// -----------------------------------------------------------------------------
// trig_acq_pkg
// Shared types for the trigger/acquisition sequencer:
//   state_t       - sequencer state encoding
//   MODE_*        - acquisition mode codes (2'b11 behaves as MODE_NORMAL)
// -----------------------------------------------------------------------------
package trig_acq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE_FILL  = 3'd1,
        WAIT_TRIG = 3'd2,
        POST_FILL = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;

endpackage

// File: rtl/trig_interval_cnt.sv
// -----------------------------------------------------------------------------
// trig_interval_cnt
// Interval counter with synchronous clear and terminal-count compare.
// The terminal value is captured on sclr, so the length seen by the sequencer
// is the one present when the interval starts.
// Ports:
//   cnt_clk  - clock
//   cnt_clr  - asynchronous active-low reset
//   sclr     - clear count to 0 and capture term
//   en       - increment count
//   term     - terminal value captured on sclr
//   tc       - count equals captured terminal value
// -----------------------------------------------------------------------------
module trig_interval_cnt
    import trig_acq_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             cnt_clk,
    input  logic             cnt_clr,
    input  logic             sclr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] term_q;

    always_ff @(posedge cnt_clk or negedge cnt_clr) begin
        if (!cnt_clr) begin
            cnt    <= '0;
            term_q <= '0;
        end else if (sclr) begin
            cnt    <= '0;
            term_q <= term;
        end else if (en) begin
            cnt <= cnt + ONE;
        end
    end

    assign tc = (cnt == term_q);

endmodule

// File: rtl/trig_acq_ctrl.sv
// -----------------------------------------------------------------------------
// trig_acq_ctrl
// Trigger/acquisition sequencer downstream of the pulse-width qualifier.
// Turns the rising edge of the qualified status level into a one-cycle
// trigger and sequences pre-fill, post-fill and holdoff.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | waiting for arm, memory writes off
//   PRE_FILL  | writing pretrig_len samples, edges ignored
//   WAIT_TRIG | writing, waiting for edge (or timeout in auto mode)
//   POST_FILL | writing max(posttrig_len,1) samples incl. trigger cycle
//   HOLDOFF   | acq_done cycle, then holdoff_len ignored cycles
//
// Ports:
//   cnt_clk, cnt_clr    - clock, async active-low reset
//   pul_trig_status     - qualified trigger level
//   arm, abort, mode    - control (arm pulse, abort level, mode code)
//   pretrig_len, posttrig_len, holdoff_len, auto_timeout - interval lengths
//   trig_out, trig_forced, acq_wr_en, acq_done, busy, trig_count - status
// -----------------------------------------------------------------------------
module trig_acq_ctrl
    import trig_acq_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int TCNT_W = 16
) (
    input  logic              cnt_clk,
    input  logic              cnt_clr,
    input  logic              pul_trig_status,
    input  logic              arm,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  pretrig_len,
    input  logic [CNT_W-1:0]  posttrig_len,
    input  logic [CNT_W-1:0]  holdoff_len,
    input  logic [CNT_W-1:0]  auto_timeout,
    output logic              trig_out,
    output logic              trig_forced,
    output logic              acq_wr_en,
    output logic              acq_done,
    output logic              busy,
    output logic [TCNT_W-1:0] trig_count
);

    localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);
    localparam logic [TCNT_W-1:0] T_ONE = TCNT_W'(1);

    state_t           state, nxt;
    logic             status_d, edge_det;
    logic [1:0]       mode_q;
    logic             fire, forced, done;
    logic             fill_sclr, fill_en, fill_tc;
    logic             to_sclr, to_en, to_tc;
    logic [CNT_W-1:0] fill_term, to_term;
    logic [CNT_W-1:0] pre_term, post_term, to_term_in;

    assign edge_det   = pul_trig_status & ~status_d;
    assign pre_term   = pretrig_len - ONE;
    assign post_term  = (posttrig_len == '0) ? '0 : posttrig_len - ONE;
    // timeout 0 and 1 both fire on the first WAIT_TRIG cycle
    assign to_term_in = (auto_timeout == '0) ? '0 : auto_timeout - ONE;

    assign fill_en = (state == PRE_FILL) || (state == POST_FILL) || (state == HOLDOFF);
    assign to_en   = (state == WAIT_TRIG);

    always_comb begin
        nxt       = state;
        fire      = 1'b0;
        forced    = 1'b0;
        done      = 1'b0;
        fill_sclr = 1'b0;
        fill_term = '0;
        to_sclr   = 1'b0;
        to_term   = '0;
        case (state)
            IDLE: begin
                if (arm) begin
                    if (pretrig_len == '0) begin
                        nxt     = WAIT_TRIG;
                        to_sclr = 1'b1;
                        to_term = to_term_in;
                    end else begin
                        nxt       = PRE_FILL;
                        fill_sclr = 1'b1;
                        fill_term = pre_term;
                    end
                end
            end
            PRE_FILL: begin
                if (fill_tc) begin
                    nxt     = WAIT_TRIG;
                    to_sclr = 1'b1;
                    to_term = to_term_in;
                end
            end
            WAIT_TRIG: begin
                // a real edge always wins over a coincident timeout
                if (edge_det) begin
                    fire = 1'b1;
                end else if (mode_q == MODE_AUTO && to_tc) begin
                    fire   = 1'b1;
                    forced = 1'b1;
                end
                if (fire) begin
                    nxt       = POST_FILL;
                    fill_sclr = 1'b1;
                    fill_term = post_term;
                end
            end
            POST_FILL: begin
                if (fill_tc) begin
                    nxt       = HOLDOFF;
                    done      = 1'b1;
                    fill_sclr = 1'b1;
                    // done cycle is count 0, so holdoff_len extra cycles follow it
                    fill_term = holdoff_len;
                end
            end
            HOLDOFF: begin
                if (fill_tc) begin
                    if (mode == MODE_SINGLE) begin
                        nxt = IDLE;
                    end else if (pretrig_len == '0) begin
                        nxt     = WAIT_TRIG;
                        to_sclr = 1'b1;
                        to_term = to_term_in;
                    end else begin
                        nxt       = PRE_FILL;
                        fill_sclr = 1'b1;
                        fill_term = pre_term;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
        if (abort) begin
            nxt       = IDLE;
            fire      = 1'b0;
            forced    = 1'b0;
            done      = 1'b0;
            fill_sclr = 1'b0;
            to_sclr   = 1'b0;
        end
    end

    always_ff @(posedge cnt_clk or negedge cnt_clr) begin
        if (!cnt_clr) begin
            state       <= IDLE;
            status_d    <= 1'b0;
            mode_q      <= MODE_NORMAL;
            trig_out    <= 1'b0;
            trig_forced <= 1'b0;
            acq_wr_en   <= 1'b0;
            acq_done    <= 1'b0;
            busy        <= 1'b0;
            trig_count  <= '0;
        end else begin
            state       <= nxt;
            status_d    <= pul_trig_status;
            trig_out    <= fire;
            trig_forced <= forced;
            acq_done    <= done;
            acq_wr_en   <= (nxt == PRE_FILL) || (nxt == WAIT_TRIG) || (nxt == POST_FILL);
            busy        <= (nxt != IDLE);
            // mode only takes effect when the sequencer changes state
            if (nxt != state) mode_q <= mode;
            if (fire) trig_count <= trig_count + T_ONE;
        end
    end

    trig_interval_cnt #(.CNT_W(CNT_W)) u_fill_cnt (
        .cnt_clk (cnt_clk),
        .cnt_clr (cnt_clr),
        .sclr    (fill_sclr),
        .en      (fill_en),
        .term    (fill_term),
        .tc      (fill_tc)
    );

    trig_interval_cnt #(.CNT_W(CNT_W)) u_timeout_cnt (
        .cnt_clk (cnt_clk),
        .cnt_clr (cnt_clr),
        .sclr    (to_sclr),
        .en      (to_en),
        .term    (to_term),
        .tc      (to_tc)
    );

endmodule

// File: tb/tb_trig_acq_ctrl.sv
module tb_trig_acq_ctrl;
    import trig_acq_pkg::*;

    localparam int CNT_W = 32;
    // narrow trigger counter so the wrap scenario stays short
    localparam int TC_W  = 8;

    logic             cnt_clk;
    logic             cnt_clr;
    logic             pul_trig_status;
    logic             arm;
    logic             abort;
    logic [1:0]       mode;
    logic [CNT_W-1:0] pretrig_len, posttrig_len, holdoff_len, auto_timeout;
    logic             trig_out, trig_forced, acq_wr_en, acq_done, busy;
    logic [TC_W-1:0]  trig_count;

    trig_acq_ctrl #(.CNT_W(CNT_W), .TCNT_W(TC_W)) dut (
        .cnt_clk         (cnt_clk),
        .cnt_clr         (cnt_clr),
        .pul_trig_status (pul_trig_status),
        .arm             (arm),
        .abort           (abort),
        .mode            (mode),
        .pretrig_len     (pretrig_len),
        .posttrig_len    (posttrig_len),
        .holdoff_len     (holdoff_len),
        .auto_timeout    (auto_timeout),
        .trig_out        (trig_out),
        .trig_forced     (trig_forced),
        .acq_wr_en       (acq_wr_en),
        .acq_done        (acq_done),
        .busy            (busy),
        .trig_count      (trig_count)
    );

    typedef struct {
        int cyc;
        bit done;
        bit forced;
    } ev_t;

    ev_t             exp_q[$];
    ev_t             exp_e;
    int              total  = 0;
    int              passed = 0;
    int              cyc    = 0;
    logic [TC_W-1:0] tcnt_exp = '0;

    initial cnt_clk = 1'b0;
    always #5 cnt_clk = ~cnt_clk;
    always @(posedge cnt_clk) cyc <= cyc + 1;

    // scoreboard: every trig_out / acq_done pulse must match the queue head
    always @(negedge cnt_clk) begin
        if (cnt_clr && (trig_out || acq_done || trig_forced)) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL event_unexpected: cyc=%0d trig=%b forced=%b done=%b, required none",
                         cyc, trig_out, trig_forced, acq_done);
            end else begin
                exp_e = exp_q.pop_front();
                if (cyc != exp_e.cyc || acq_done !== exp_e.done || trig_out !== !exp_e.done ||
                    trig_forced !== exp_e.forced)
                    $display("FAIL event: cyc=%0d trig=%b forced=%b done=%b, required cyc=%0d trig=%b forced=%b done=%b",
                             cyc, trig_out, trig_forced, acq_done,
                             exp_e.cyc, !exp_e.done, exp_e.forced, exp_e.done);
                else passed++;
            end
        end
    end

    task automatic push_ev(input int c, input bit d, input bit f);
        ev_t e;
        e.cyc = c; e.done = d; e.forced = f;
        exp_q.push_back(e);
    endtask

    task automatic goto(input int k);
        while (cyc < k) @(negedge cnt_clk);
    endtask

    task automatic go_idle();
        abort = 1'b1;
        @(negedge cnt_clk);
        abort = 1'b0;
        pul_trig_status = 1'b0;
        repeat (2) @(negedge cnt_clk);
    endtask

    task automatic test_reset();
        cnt_clr = 1'b0;
        repeat (2) @(negedge cnt_clk);
        total++;
        if ({trig_out, trig_forced, acq_wr_en, acq_done, busy} !== 5'b0)
            $display("FAIL reset_flags: got %b, required 00000",
                     {trig_out, trig_forced, acq_wr_en, acq_done, busy});
        else passed++;
        total++;
        if (trig_count !== '0) $display("FAIL reset_count: got %0h, required 0", trig_count);
        else passed++;
        cnt_clr = 1'b1;
        repeat (2) @(negedge cnt_clk);
        total++;
        if (busy !== 1'b0 || acq_wr_en !== 1'b0)
            $display("FAIL reset_idle: busy=%b wr=%b, required 0 0", busy, acq_wr_en);
        else passed++;
    endtask

    task automatic test_normal();
        int c0, wr_cnt;
        @(negedge cnt_clk); c0 = cyc;
        mode = MODE_NORMAL; pretrig_len = 4; posttrig_len = 6; holdoff_len = 3; auto_timeout = 0;
        arm = 1'b1;
        push_ev(c0 + 15, 0, 0);
        push_ev(c0 + 21, 1, 0);
        wr_cnt = 0;
        for (int k = c0 + 1; k <= c0 + 25; k++) begin
            goto(k);
            if (k == c0 + 1) arm = 1'b0;
            if (k == c0 + 14) pul_trig_status = 1'b1;
            if (k == c0 + 16) pul_trig_status = 1'b0;
            if (k <= c0 + 21 && acq_wr_en) wr_cnt++;
            if (k == c0 + 24) begin
                total++;
                if (acq_wr_en !== 1'b0 || busy !== 1'b1)
                    $display("FAIL normal_holdoff: wr=%b busy=%b, required 0 1", acq_wr_en, busy);
                else passed++;
            end
            if (k == c0 + 25) begin
                total++;
                if (acq_wr_en !== 1'b1)
                    $display("FAIL normal_rearm: wr=%b, required 1", acq_wr_en);
                else passed++;
            end
        end
        tcnt_exp++;
        total++;
        if (wr_cnt != 20) $display("FAIL normal_wr_cycles: got %0d, required 20", wr_cnt);
        else passed++;
        total++;
        if (trig_count !== tcnt_exp)
            $display("FAIL normal_count: got %0h, required %0h", trig_count, tcnt_exp);
        else passed++;
        go_idle();
        total++;
        if (exp_q.size() != 0 || busy !== 1'b0)
            $display("FAIL normal_end: pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
        else passed++;
    endtask

    task automatic test_ignore_edges();
        int c0;
        @(negedge cnt_clk); c0 = cyc;
        mode = MODE_NORMAL; pretrig_len = 4; posttrig_len = 2; holdoff_len = 4;
        arm = 1'b1;
        push_ev(c0 + 13, 0, 0);
        push_ev(c0 + 15, 1, 0);
        for (int k = c0 + 1; k <= c0 + 30; k++) begin
            goto(k);
            case (k - c0)
                1:  begin arm = 1'b0; pul_trig_status = 1'b1; end
                2:  pul_trig_status = 1'b0;
                4:  pul_trig_status = 1'b1;
                8:  pul_trig_status = 1'b0;
                12: pul_trig_status = 1'b1;
                14: pul_trig_status = 1'b0;
                16: pul_trig_status = 1'b1;
                17: pul_trig_status = 1'b0;
                20: pul_trig_status = 1'b1;
                21: pul_trig_status = 1'b0;
                default: ;
            endcase
            if (k == c0 + 19) begin
                total++;
                if (acq_wr_en !== 1'b0) $display("FAIL ignore_holdoff_wr: got %b, required 0", acq_wr_en);
                else passed++;
            end
            if (k == c0 + 29) begin
                total++;
                if (acq_wr_en !== 1'b1 || busy !== 1'b1)
                    $display("FAIL ignore_wait: wr=%b busy=%b, required 1 1", acq_wr_en, busy);
                else passed++;
            end
        end
        tcnt_exp++;
        go_idle();
        total++;
        if (exp_q.size() != 0 || trig_count !== tcnt_exp)
            $display("FAIL ignore_end: pending=%0d count=%0h, required 0 %0h",
                     exp_q.size(), trig_count, tcnt_exp);
        else passed++;
    endtask

    task automatic test_auto();
        int c0;
        @(negedge cnt_clk); c0 = cyc;
        mode = MODE_AUTO; pretrig_len = 2; posttrig_len = 3; holdoff_len = 0; auto_timeout = 20;
        arm = 1'b1;
        push_ev(c0 + 23, 0, 1);
        push_ev(c0 + 26, 1, 0);
        push_ev(c0 + 49, 0, 0);
        for (int k = c0 + 1; k <= c0 + 56; k++) begin
            goto(k);
            if (k == c0 + 1) arm = 1'b0;
            if (k == c0 + 48) pul_trig_status = 1'b1;
            if (k == c0 + 50) begin abort = 1'b1; pul_trig_status = 1'b0; end
            if (k == c0 + 51) begin
                abort = 1'b0;
                total++;
                if (acq_wr_en !== 1'b0 || busy !== 1'b0)
                    $display("FAIL auto_abort: wr=%b busy=%b, required 0 0", acq_wr_en, busy);
                else passed++;
            end
        end
        tcnt_exp += 2;
        total++;
        if (exp_q.size() != 0 || trig_count !== tcnt_exp)
            $display("FAIL auto_end: pending=%0d count=%0h, required 0 %0h",
                     exp_q.size(), trig_count, tcnt_exp);
        else passed++;
    endtask

    task automatic test_single();
        int c0;
        @(negedge cnt_clk); c0 = cyc;
        mode = MODE_SINGLE; pretrig_len = 1; posttrig_len = 2; holdoff_len = 2; auto_timeout = 5;
        arm = 1'b1;
        push_ev(c0 + 4, 0, 0);
        push_ev(c0 + 6, 1, 0);
        push_ev(c0 + 20, 0, 0);
        push_ev(c0 + 22, 1, 0);
        for (int k = c0 + 1; k <= c0 + 26; k++) begin
            goto(k);
            case (k - c0)
                1:  arm = 1'b0;
                3:  pul_trig_status = 1'b1;
                5:  pul_trig_status = 1'b0;
                12: pul_trig_status = 1'b1;
                13: pul_trig_status = 1'b0;
                16: arm = 1'b1;
                17: arm = 1'b0;
                19: pul_trig_status = 1'b1;
                21: pul_trig_status = 1'b0;
                default: ;
            endcase
            if (k == c0 + 9 || k == c0 + 15 || k == c0 + 26) begin
                total++;
                if (busy !== 1'b0 || acq_wr_en !== 1'b0)
                    $display("FAIL single_idle@%0d: busy=%b wr=%b, required 0 0", k - c0, busy, acq_wr_en);
                else passed++;
            end
            if (k == c0 + 18) begin
                total++;
                if (busy !== 1'b1) $display("FAIL single_rearm: busy=%b, required 1", busy);
                else passed++;
            end
        end
        tcnt_exp += 2;
        total++;
        if (exp_q.size() != 0 || trig_count !== tcnt_exp)
            $display("FAIL single_end: pending=%0d count=%0h, required 0 %0h",
                     exp_q.size(), trig_count, tcnt_exp);
        else passed++;
    endtask

    task automatic test_abort_reset();
        int c0;
        @(negedge cnt_clk); c0 = cyc;
        mode = MODE_NORMAL; pretrig_len = 0; posttrig_len = 5; holdoff_len = 1;
        arm = 1'b1;
        push_ev(c0 + 2, 0, 0);
        for (int k = c0 + 1; k <= c0 + 13; k++) begin
            goto(k);
            case (k - c0)
                1:  begin arm = 1'b0; pul_trig_status = 1'b1; end
                3:  abort = 1'b1;
                4:  begin abort = 1'b0; pul_trig_status = 1'b0; end
                11: arm = 1'b1;
                12: arm = 1'b0;
                default: ;
            endcase
            if (k == c0 + 4) begin
                total++;
                if (acq_wr_en !== 1'b0 || busy !== 1'b0 || acq_done !== 1'b0)
                    $display("FAIL abort_post: wr=%b busy=%b done=%b, required 0 0 0",
                             acq_wr_en, busy, acq_done);
                else passed++;
            end
        end
        tcnt_exp++;
        total++;
        if (trig_count !== tcnt_exp || acq_wr_en !== 1'b1)
            $display("FAIL abort_prereset: count=%0h wr=%b, required %0h 1", trig_count, acq_wr_en, tcnt_exp);
        else passed++;
        goto(c0 + 14);
        cnt_clr = 1'b0;
        #1;
        tcnt_exp = '0;
        total++;
        if ({trig_out, trig_forced, acq_wr_en, acq_done, busy} !== 5'b0 || trig_count !== tcnt_exp)
            $display("FAIL clr_midop: flags=%b count=%0h, required 00000 0",
                     {trig_out, trig_forced, acq_wr_en, acq_done, busy}, trig_count);
        else passed++;
        goto(c0 + 15);
        cnt_clr = 1'b1;
        goto(c0 + 17);
        total++;
        if (busy !== 1'b0 || exp_q.size() != 0)
            $display("FAIL clr_after: busy=%b pending=%0d, required 0 0", busy, exp_q.size());
        else passed++;
    endtask

    task automatic test_boundary();
        int c0;
        @(negedge cnt_clk); c0 = cyc;
        mode = MODE_NORMAL; pretrig_len = 0; posttrig_len = 0; holdoff_len = 0;
        arm = 1'b1;
        push_ev(c0 + 3, 0, 0);
        push_ev(c0 + 4, 1, 0);
        push_ev(c0 + 7, 0, 0);
        push_ev(c0 + 8, 1, 0);
        for (int k = c0 + 1; k <= c0 + 9; k++) begin
            goto(k);
            case (k - c0)
                1: arm = 1'b0;
                2: pul_trig_status = 1'b1;
                3: pul_trig_status = 1'b0;
                6: pul_trig_status = 1'b1;
                7: pul_trig_status = 1'b0;
                default: ;
            endcase
            if (k == c0 + 1 || k == c0 + 3 || k == c0 + 5) begin
                total++;
                if (acq_wr_en !== 1'b1) $display("FAIL bound_wr_on@%0d: got %b, required 1", k - c0, acq_wr_en);
                else passed++;
            end
            if (k == c0 + 4) begin
                total++;
                if (acq_wr_en !== 1'b0) $display("FAIL bound_wr_off: got %b, required 0", acq_wr_en);
                else passed++;
            end
        end
        tcnt_exp += 2;
        go_idle();
        total++;
        if (exp_q.size() != 0 || trig_count !== tcnt_exp)
            $display("FAIL bound_end: pending=%0d count=%0h, required 0 %0h",
                     exp_q.size(), trig_count, tcnt_exp);
        else passed++;
    endtask

    task automatic test_wrap();
        int c0;
        cnt_clr = 1'b0;
        @(negedge cnt_clk);
        cnt_clr = 1'b1;
        tcnt_exp = '0;
        @(negedge cnt_clk); c0 = cyc;
        mode = MODE_AUTO; pretrig_len = 0; posttrig_len = 0; holdoff_len = 0; auto_timeout = 0;
        arm = 1'b1;
        for (int i = 0; i < 256; i++) begin
            push_ev(c0 + 2 + 3 * i, 0, 1);
            push_ev(c0 + 3 + 3 * i, 1, 0);
        end
        goto(c0 + 1);
        arm = 1'b0;
        goto(c0 + 764);
        tcnt_exp = '1;
        total++;
        if (trig_count !== tcnt_exp) $display("FAIL wrap_max: got %0h, required %0h", trig_count, tcnt_exp);
        else passed++;
        goto(c0 + 767);
        tcnt_exp = '0;
        total++;
        if (trig_count !== tcnt_exp) $display("FAIL wrap_zero: got %0h, required %0h", trig_count, tcnt_exp);
        else passed++;
        goto(c0 + 768);
        go_idle();
        total++;
        if (exp_q.size() != 0 || trig_count !== tcnt_exp)
            $display("FAIL wrap_end: pending=%0d count=%0h, required 0 %0h",
                     exp_q.size(), trig_count, tcnt_exp);
        else passed++;
    endtask

    initial begin
        pul_trig_status = 1'b0;
        arm = 1'b0;
        abort = 1'b0;
        mode = MODE_NORMAL;
        pretrig_len = '0;
        posttrig_len = '0;
        holdoff_len = '0;
        auto_timeout = '0;
        test_reset();
        test_normal();
        test_ignore_edges();
        test_auto();
        test_single();
        test_abort_reset();
        test_boundary();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
